// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipe: tracks in-flight destinations,
// drives EX operand forwarding, the ID branch bypass and the stall/bubble controls.
module hazard_ctrl #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            id_instr,
    input  logic                   id_valid,
    input  logic                   mem_wait,
    output logic                   ex_forward_a,
    output logic                   mem_forward_a,
    output logic                   ex_forward_b,
    output logic                   mem_forward_b,
    output logic [1:0]             br_fwd_sel,
    output logic                   stall_pc,
    output logic                   stall_ifid,
    output logic                   bubble_ex,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BLTZ  = 6'b000001;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [STALL_CNT_W-1:0] CNT_ONE = 1;

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       unused_shamt;

    assign op           = id_instr[31:26];
    assign rs           = id_instr[25:21];
    assign rt           = id_instr[20:16];
    assign rd           = id_instr[15:11];
    assign funct        = id_instr[5:0];
    assign unused_shamt = ^id_instr[10:6];

    logic       reads_rs;
    logic       reads_rt;
    logic       writes;
    logic       is_load;
    logic       is_branch;
    logic [4:0] wr_dst;

    always_comb begin
        reads_rs  = 1'b0;
        reads_rt  = 1'b0;
        writes    = 1'b0;
        is_load   = 1'b0;
        is_branch = 1'b0;
        wr_dst    = 5'd0;
        case (op)
            OP_RTYPE: begin
                reads_rs = 1'b1;
                if (funct == FN_JR) begin
                    is_branch = 1'b1;
                end else begin
                    reads_rt = 1'b1;
                    writes   = 1'b1;
                    wr_dst   = rd;
                end
            end
            OP_BLTZ: begin
                reads_rs  = 1'b1;
                is_branch = 1'b1;
            end
            OP_ADDI: begin
                reads_rs = 1'b1;
                writes   = 1'b1;
                wr_dst   = rt;
            end
            OP_LW: begin
                reads_rs = 1'b1;
                writes   = 1'b1;
                is_load  = 1'b1;
                wr_dst   = rt;
            end
            OP_SW: begin
                reads_rs = 1'b1;
                reads_rt = 1'b1;
            end
            OP_J: begin
            end
            default: begin
            end
        endcase
    end

    // $0 is never a real producer or consumer, so it is filtered out here once.
    logic use_rs;
    logic use_rt;
    logic dec_wr;
    assign use_rs = id_valid & reads_rs & (rs != 5'd0);
    assign use_rt = id_valid & reads_rt & (rt != 5'd0);
    assign dec_wr = writes & (wr_dst != 5'd0);

    logic       ex_v_reg;
    logic [4:0] ex_dst_reg;
    logic       ex_load_reg;
    logic       mem_v_reg;
    logic [4:0] mem_dst_reg;
    logic       mem_load_reg;
    logic       wb_v_reg;
    logic [4:0] wb_dst_reg;

    logic load_use;
    logic br_rs;
    logic branch_hz;
    logic hazard;

    assign load_use  = id_valid & ~is_branch & ex_v_reg & ex_load_reg &
                       ((use_rs & (ex_dst_reg == rs)) | (use_rt & (ex_dst_reg == rt)));
    assign br_rs     = id_valid & is_branch & (rs != 5'd0);
    assign branch_hz = br_rs & ((ex_v_reg & (ex_dst_reg == rs)) |
                                (mem_v_reg & mem_load_reg & (mem_dst_reg == rs)));
    assign hazard    = load_use | branch_hz;

    assign stall_pc   = mem_wait | hazard;
    assign stall_ifid = mem_wait | hazard;
    assign bubble_ex  = ~mem_wait & hazard;

    always_comb begin
        br_fwd_sel = 2'b00;
        if (br_rs && !hazard) begin
            if (mem_v_reg && !mem_load_reg && (mem_dst_reg == rs))
                br_fwd_sel = 2'b01;
            else if (wb_v_reg && (wb_dst_reg == rs))
                br_fwd_sel = 2'b10;
        end
    end

    // Operand 0 is A (rs), operand 1 is B (rt); EX/MEM beats MEM/WB.
    logic [1:0][4:0] src;
    logic [1:0]      src_used;
    logic [1:0]      ex_fwd_next;
    logic [1:0]      mem_fwd_next;
    logic [1:0]      ex_fwd_reg;
    logic [1:0]      mem_fwd_reg;

    assign src[0]   = rs;
    assign src[1]   = rt;
    assign src_used = {use_rt, use_rs};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            assign ex_fwd_next[gi]  = ~hazard & src_used[gi] & ex_v_reg &
                                      (ex_dst_reg == src[gi]);
            assign mem_fwd_next[gi] = ~hazard & src_used[gi] & mem_v_reg &
                                      (mem_dst_reg == src[gi]) & ~ex_fwd_next[gi];
        end
    endgenerate

    logic [STALL_CNT_W-1:0] stall_cycles_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_v_reg         <= 1'b0;
            ex_dst_reg       <= 5'd0;
            ex_load_reg      <= 1'b0;
            mem_v_reg        <= 1'b0;
            mem_dst_reg      <= 5'd0;
            mem_load_reg     <= 1'b0;
            wb_v_reg         <= 1'b0;
            wb_dst_reg       <= 5'd0;
            ex_fwd_reg       <= 2'b00;
            mem_fwd_reg      <= 2'b00;
            stall_cycles_reg <= '0;
        end else if (!mem_wait) begin
            wb_v_reg     <= mem_v_reg;
            wb_dst_reg   <= mem_dst_reg;
            mem_v_reg    <= ex_v_reg;
            mem_dst_reg  <= ex_dst_reg;
            mem_load_reg <= ex_load_reg;
            ex_v_reg     <= id_valid & ~hazard & dec_wr;
            ex_dst_reg   <= wr_dst;
            ex_load_reg  <= is_load;
            ex_fwd_reg   <= ex_fwd_next;
            mem_fwd_reg  <= mem_fwd_next;
            if (hazard && (stall_cycles_reg != '1))
                stall_cycles_reg <= stall_cycles_reg + CNT_ONE;
        end
    end

    assign ex_forward_a  = ex_fwd_reg[0];
    assign mem_forward_a = mem_fwd_reg[0];
    assign ex_forward_b  = ex_fwd_reg[1];
    assign mem_forward_b = mem_fwd_reg[1];
    assign stall_cycles  = stall_cycles_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed scenarios plus randomized instruction
// streams checked against an instruction-history reference model.
module tb_hazard_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   id_instr;
    logic          id_valid;
    logic          mem_wait;
    logic          ex_forward_a;
    logic          mem_forward_a;
    logic          ex_forward_b;
    logic          mem_forward_b;
    logic [1:0]    br_fwd_sel;
    logic          stall_pc;
    logic          stall_ifid;
    logic          bubble_ex;
    logic [CW-1:0] stall_cycles;

    always #5 clk = ~clk;

    hazard_ctrl #(.STALL_CNT_W(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_instr      (id_instr),
        .id_valid      (id_valid),
        .mem_wait      (mem_wait),
        .ex_forward_a  (ex_forward_a),
        .mem_forward_a (mem_forward_a),
        .ex_forward_b  (ex_forward_b),
        .mem_forward_b (mem_forward_b),
        .br_fwd_sel    (br_fwd_sel),
        .stall_pc      (stall_pc),
        .stall_ifid    (stall_ifid),
        .bubble_ex     (bubble_ex),
        .stall_cycles  (stall_cycles)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    wire [2:0] stl = {stall_pc, stall_ifid, bubble_ex};
    wire [3:0] fwd = {ex_forward_a, mem_forward_a, ex_forward_b, mem_forward_b};

    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLTU = 6'b101011;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_JR   = 6'b001000;

    function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
        return {6'b000000, s, t, d, 5'b00000, fn};
    endfunction
    function automatic logic [31:0] addi(input logic [4:0] t, input logic [4:0] s, input logic [15:0] imm);
        return {6'b001000, s, t, imm};
    endfunction
    function automatic logic [31:0] lw(input logic [4:0] t, input logic [4:0] s);
        return {6'b100011, s, t, 16'h0000};
    endfunction
    function automatic logic [31:0] sw(input logic [4:0] t, input logic [4:0] s);
        return {6'b101011, s, t, 16'h0004};
    endfunction
    function automatic logic [31:0] bltz(input logic [4:0] s);
        return {6'b000001, s, 5'd0, 16'h0008};
    endfunction
    function automatic logic [31:0] jr(input logic [4:0] s);
        return rtype(FN_JR, s, 5'd0, 5'd0);
    endfunction
    function automatic logic [31:0] jmp();
        return {6'b000010, 26'h0000040};
    endfunction

    // Reference model: each entry is what entered EX on a non-frozen edge.
    typedef struct packed { logic [4:0] dst; logic load; } rec_t;
    typedef struct packed { logic rd_rs; logic rd_rt; logic [4:0] dst; logic load; logic br; } dec_t;

    rec_t          hist[$];
    logic [3:0]    fwd_m;
    logic [CW-1:0] cnt_m;

    function automatic dec_t mdec(input logic [31:0] i);
        dec_t d = '0;
        case (i[31:26])
            6'b000000: begin
                d.rd_rs = 1'b1;
                if (i[5:0] == 6'b001000) d.br = 1'b1;
                else begin d.rd_rt = 1'b1; d.dst = i[15:11]; end
            end
            6'b000001: begin d.rd_rs = 1'b1; d.br = 1'b1; end
            6'b001000: begin d.rd_rs = 1'b1; d.dst = i[20:16]; end
            6'b100011: begin d.rd_rs = 1'b1; d.dst = i[20:16]; d.load = 1'b1; end
            6'b101011: begin d.rd_rs = 1'b1; d.rd_rt = 1'b1; end
            default: begin end
        endcase
        return d;
    endfunction

    function automatic rec_t prior(input int dd);
        if (hist.size() >= dd) return hist[hist.size() - dd];
        return '0;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0] s = 5'($urandom_range(0, 3));
        logic [4:0] t = 5'($urandom_range(0, 3));
        logic [4:0] d = 5'($urandom_range(0, 3));
        case ($urandom_range(0, 9))
            0: return rtype(FN_NOR, s, t, d);
            1: return rtype(FN_SLTU, s, t, d);
            2: return rtype(FN_SUBU, s, t, d);
            3: return addi(t, s, 16'h0011);
            4: return lw(t, s);
            5: return sw(t, s);
            6: return bltz(s);
            7: return jr(s);
            8: return jmp();
            default: return {6'b111111, s, t, 16'h0000};
        endcase
    endfunction

    task automatic tick(input logic [31:0] ins, input logic v, input logic w, input logic r);
        @(negedge clk);
        id_instr = ins;
        id_valid = v;
        mem_wait = w;
        rst      = r;
        #1;
        cyc++;
        $display("cyc %0d instr=%08h v=%0b wait=%0b rst=%0b : stall=%b sel=%b fwd=%b cnt=%0d",
                 cyc, ins, v, w, r, stl, br_fwd_sel, fwd, stall_cycles);
    endtask

    task automatic do_reset();
        tick(32'h0, 1'b0, 1'b0, 1'b1);
        tick(32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        tick(32'h0, 1'b0, 1'b1, 1'b1);
        tick(32'h0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (stl !== 3'b000) begin n_fail++; $display("FAIL reset_stall got=%b exp=000", stl); end
        n_checks++; if (fwd !== 4'b0000 || br_fwd_sel !== 2'b00) begin n_fail++; $display("FAIL reset_fwd got=%b/%b exp=0000/00", fwd, br_fwd_sel); end
        n_checks++; if (stall_cycles !== '0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", stall_cycles); end
    endtask

    task automatic test_forward_ex();
        do_reset();
        tick(addi(5'd1, 5'd0, 16'd5), 1'b1, 1'b0, 1'b0);
        tick(rtype(FN_SUBU, 5'd1, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0);
        n_checks++; if (stl !== 3'b000) begin n_fail++; $display("FAIL fwd_ex_nostall got=%b exp=000", stl); end
        tick(32'h0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (fwd !== 4'b1010) begin n_fail++; $display("FAIL fwd_ex_ab got=%b exp=1010", fwd); end
    endtask

    task automatic test_forward_mem();
        do_reset();
        tick(addi(5'd1, 5'd0, 16'd5), 1'b1, 1'b0, 1'b0);
        tick(rtype(FN_NOR, 5'd0, 5'd0, 5'd3), 1'b1, 1'b0, 1'b0);
        tick(rtype(FN_SLTU, 5'd1, 5'd0, 5'd4), 1'b1, 1'b0, 1'b0);
        n_checks++; if (stl !== 3'b000) begin n_fail++; $display("FAIL fwd_mem_nostall got=%b exp=000", stl); end
        tick(32'h0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (fwd !== 4'b0100) begin n_fail++; $display("FAIL fwd_mem_a got=%b exp=0100", fwd); end
        tick(addi(5'd1, 5'd0, 16'd1), 1'b1, 1'b0, 1'b0);
        tick(addi(5'd1, 5'd1, 16'd2), 1'b1, 1'b0, 1'b0);
        tick(rtype(FN_SLTU, 5'd1, 5'd0, 5'd4), 1'b1, 1'b0, 1'b0);
        tick(32'h0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (fwd !== 4'b1000) begin n_fail++; $display("FAIL fwd_priority got=%b exp=1000", fwd); end
    endtask

    task automatic test_load_use();
        do_reset();
        tick(lw(5'd5, 5'd0), 1'b1, 1'b0, 1'b0);
        n_checks++; if (stl !== 3'b000) begin n_fail++; $display("FAIL lu_pre got=%b exp=000", stl); end
        tick(addi(5'd6, 5'd5, 16'd1), 1'b1, 1'b0, 1'b0);
        n_checks++; if (stl !== 3'b111) begin n_fail++; $display("FAIL lu_stall got=%b exp=111", stl); end
        tick(addi(5'd6, 5'd5, 16'd1), 1'b1, 1'b0, 1'b0);
        n_checks++; if (stl !== 3'b000) begin n_fail++; $display("FAIL lu_release got=%b exp=000", stl); end
        tick(32'h0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (fwd !== 4'b0100) begin n_fail++; $display("FAIL lu_memfwd got=%b exp=0100", fwd); end
        n_checks++; if (stall_cycles !== 4'd1) begin n_fail++; $display("FAIL lu_cnt got=%0d exp=1", stall_cycles); end
    endtask

    task automatic test_branch();
        do_reset();
        tick(lw(5'd7, 5'd0), 1'b1, 1'b0, 1'b0);
        tick(bltz(5'd7), 1'b1, 1'b0, 1'b0);
        n_checks++; if (stl !== 3'b111) begin n_fail++; $display("FAIL br_lw_stall1 got=%b exp=111", stl); end
        tick(bltz(5'd7), 1'b1, 1'b0, 1'b0);
        n_checks++; if (stl !== 3'b111) begin n_fail++; $display("FAIL br_lw_stall2 got=%b exp=111", stl); end
        tick(bltz(5'd7), 1'b1, 1'b0, 1'b0);
        n_checks++; if ({stl, br_fwd_sel} !== 5'b000_10) begin n_fail++; $display("FAIL br_lw_sel got=%b/%b exp=000/10", stl, br_fwd_sel); end
        n_checks++; if (stall_cycles !== 4'd2) begin n_fail++; $display("FAIL br_lw_cnt got=%0d exp=2", stall_cycles); end
        tick(addi(5'd8, 5'd0, 16'd3), 1'b1, 1'b0, 1'b0);
        tick(bltz(5'd8), 1'b1, 1'b0, 1'b0);
        n_checks++; if (stl !== 3'b111) begin n_fail++; $display("FAIL br_addi_stall got=%b exp=111", stl); end
        tick(bltz(5'd8), 1'b1, 1'b0, 1'b0);
        n_checks++; if ({stl, br_fwd_sel} !== 5'b000_01) begin n_fail++; $display("FAIL br_addi_sel got=%b/%b exp=000/01", stl, br_fwd_sel); end
        tick(addi(5'd9, 5'd0, 16'd1), 1'b1, 1'b0, 1'b0);
        tick(jr(5'd9), 1'b1, 1'b0, 1'b0);
        tick(jr(5'd9), 1'b1, 1'b0, 1'b0);
        n_checks++; if ({stl, br_fwd_sel} !== 5'b000_01) begin n_fail++; $display("FAIL jr_sel got=%b/%b exp=000/01", stl, br_fwd_sel); end
        n_checks++; if (stall_cycles !== 4'd4) begin n_fail++; $display("FAIL br_cnt got=%0d exp=4", stall_cycles); end
    endtask

    task automatic test_zero_and_j();
        do_reset();
        tick(addi(5'd0, 5'd0, 16'd1), 1'b1, 1'b0, 1'b0);
        tick(rtype(FN_SUBU, 5'd0, 5'd0, 5'd2), 1'b1, 1'b0, 1'b0);
        tick(lw(5'd0, 5'd0), 1'b1, 1'b0, 1'b0);
        n_checks++; if (fwd !== 4'b0000) begin n_fail++; $display("FAIL zero_fwd got=%b exp=0000", fwd); end
        tick(addi(5'd3, 5'd0, 16'd1), 1'b1, 1'b0, 1'b0);
        n_checks++; if (stl !== 3'b000) begin n_fail++; $display("FAIL zero_lu got=%b exp=000", stl); end
        tick(lw(5'd9, 5'd0), 1'b1, 1'b0, 1'b0);
        tick(jmp(), 1'b1, 1'b0, 1'b0);
        n_checks++; if (stl !== 3'b000) begin n_fail++; $display("FAIL j_after_lw got=%b exp=000", stl); end
        tick(lw(5'd0, 5'd0), 1'b1, 1'b0, 1'b0);
        n_checks++; if (fwd !== 4'b0000) begin n_fail++; $display("FAIL j_fwd got=%b exp=0000", fwd); end
        tick(bltz(5'd0), 1'b1, 1'b0, 1'b0);
        n_checks++; if ({stl, br_fwd_sel} !== 5'b000_00) begin n_fail++; $display("FAIL zero_br got=%b/%b exp=000/00", stl, br_fwd_sel); end
    endtask

    task automatic test_mem_wait();
        do_reset();
        tick(addi(5'd1, 5'd0, 16'd1), 1'b1, 1'b0, 1'b0);
        tick(lw(5'd5, 5'd1), 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick(addi(5'd6, 5'd5, 16'd1), 1'b1, 1'b1, 1'b0);
            n_checks++; if (stl !== 3'b110) begin n_fail++; $display("FAIL wait_stall[%0d] got=%b exp=110", k, stl); end
            n_checks++; if (fwd !== 4'b1000 || stall_cycles !== 4'd0) begin n_fail++; $display("FAIL wait_hold[%0d] got=%b/%0d exp=1000/0", k, fwd, stall_cycles); end
        end
        tick(addi(5'd6, 5'd5, 16'd1), 1'b1, 1'b0, 1'b0);
        n_checks++; if (stl !== 3'b111) begin n_fail++; $display("FAIL wait_release got=%b exp=111", stl); end
        tick(addi(5'd6, 5'd5, 16'd1), 1'b1, 1'b0, 1'b0);
        n_checks++; if (stl !== 3'b000 || stall_cycles !== 4'd1) begin n_fail++; $display("FAIL wait_single got=%b/%0d exp=000/1", stl, stall_cycles); end
        tick(32'h0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (fwd !== 4'b0100) begin n_fail++; $display("FAIL wait_memfwd got=%b exp=0100", fwd); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        tick(lw(5'd5, 5'd0), 1'b1, 1'b0, 1'b0);
        tick(addi(5'd6, 5'd5, 16'd1), 1'b1, 1'b0, 1'b0);
        tick(addi(5'd6, 5'd5, 16'd1), 1'b1, 1'b1, 1'b1);
        tick(32'h0, 1'b0, 1'b0, 1'b0);
        n_checks++; if ({stl, br_fwd_sel, fwd, stall_cycles} !== 13'd0) begin n_fail++; $display("FAIL rst_mid got=%b/%b/%b/%0d exp=all zero", stl, br_fwd_sel, fwd, stall_cycles); end
        tick(addi(5'd6, 5'd5, 16'd1), 1'b1, 1'b0, 1'b0);
        n_checks++; if (stl !== 3'b000) begin n_fail++; $display("FAIL rst_no_carry got=%b exp=000", stl); end
    endtask

    task automatic test_saturate();
        logic [CW-1:0] exp_cnt;
        do_reset();
        for (int k = 1; k <= 17; k++) begin
            tick(lw(5'd5, 5'd0), 1'b1, 1'b0, 1'b0);
            tick(addi(5'd6, 5'd5, 16'd1), 1'b1, 1'b0, 1'b0);
            tick(addi(5'd6, 5'd5, 16'd1), 1'b1, 1'b0, 1'b0);
            exp_cnt = (k < 15) ? CW'(k) : '1;
            n_checks++; if (stall_cycles !== exp_cnt) begin n_fail++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", k, stall_cycles, exp_cnt); end
        end
    endtask

    task automatic test_random();
        logic [31:0] ins = 32'h0;
        logic        v = 1'b0, w, r, hold = 1'b0;
        logic        ua, ub, lu, bh, hz, fa, fb;
        logic [4:0]  rs, rt;
        logic [2:0]  e_stl;
        logic [1:0]  e_sel;
        dec_t        d;
        rec_t        p1, p2, p3, nr;
        do_reset();
        hist.delete();
        fwd_m = '0;
        cnt_m = '0;
        for (int n = 0; n < 400; n++) begin
            if (!hold) begin
                ins = rand_instr();
                v   = ($urandom_range(0, 7) != 0);
            end
            w = ($urandom_range(0, 9) == 0);
            r = ($urandom_range(0, 79) == 0);
            tick(ins, v, w, r);
            d  = mdec(ins);
            rs = ins[25:21];
            rt = ins[20:16];
            ua = v && d.rd_rs && (rs != 5'd0);
            ub = v && d.rd_rt && (rt != 5'd0);
            p1 = prior(1);
            p2 = prior(2);
            p3 = prior(3);
            lu = v && !d.br && p1.load && ((ua && p1.dst == rs) || (ub && p1.dst == rt));
            bh = v && d.br && (rs != 5'd0) && (p1.dst == rs || (p2.load && p2.dst == rs));
            hz = lu || bh;
            e_stl = {w || hz, w || hz, !w && hz};
            e_sel = 2'b00;
            if (v && d.br && (rs != 5'd0) && !hz) begin
                if (p2.dst == rs && !p2.load) e_sel = 2'b01;
                else if (p3.dst == rs)        e_sel = 2'b10;
            end
            n_checks++;
            if ({stl, br_fwd_sel, fwd, stall_cycles} !== {e_stl, e_sel, fwd_m, cnt_m}) begin
                n_fail++;
                $display("FAIL rand[%0d] got stall=%b sel=%b fwd=%b cnt=%0d exp stall=%b sel=%b fwd=%b cnt=%0d",
                         n, stl, br_fwd_sel, fwd, stall_cycles, e_stl, e_sel, fwd_m, cnt_m);
            end
            if (r) begin
                hist.delete();
                fwd_m = '0;
                cnt_m = '0;
            end else if (!w) begin
                if (hz || !v) begin
                    fwd_m = '0;
                end else begin
                    fa = ua && p1.dst == rs;
                    fb = ub && p1.dst == rt;
                    fwd_m = {fa, ua && p2.dst == rs && !fa, fb, ub && p2.dst == rt && !fb};
                end
                nr = '0;
                if (v && !hz) begin
                    nr.dst  = d.dst;
                    nr.load = d.load && (d.dst != 5'd0);
                end
                hist.push_back(nr);
                if (hist.size() > 4) void'(hist.pop_front());
                if (hz && cnt_m != '1) cnt_m = cnt_m + 1'b1;
            end
            hold = (w || hz) && !r;
        end
    endtask

    initial begin
        rst      = 1'b1;
        id_instr = 32'h0;
        id_valid = 1'b0;
        mem_wait = 1'b0;
        test_reset();
        test_forward_ex();
        test_forward_mem();
        test_load_use();
        test_branch();
        test_zero_and_j();
        test_mem_wait();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
